nbit_pipe_addsub: RTL and testbench
===================================

NBIT_PIPE_ADDSUB -- requirements
Module: nbit_pipe_addsub

Interface
REQ-001 Parameter N SHALL default to 32: operand and result width in bits.
REQ-002 Parameter STAGES SHALL default to 4: number of pipeline stages; legal range 1..N, with N mod STAGES = 0.
REQ-003 Port clk SHALL be an input of width 1: single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: asynchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input of width 1: the operand set is valid.
REQ-006 Port in_ready SHALL be an output of width 1: the block accepts the operand set this cycle.
REQ-007 Port reg_in0 SHALL be an input of width N: operand A.
REQ-008 Port reg_in1 SHALL be an input of width N: operand B.
REQ-009 Port c_in SHALL be an input of width 1: carry-in.
REQ-010 Port sub SHALL be an input of width 1: mode select; 0 = add, 1 = subtract.
REQ-011 Port out_valid SHALL be an output of width 1: the result is valid.
REQ-012 Port out_ready SHALL be an input of width 1: downstream accepts the result.
REQ-013 Port out SHALL be an output of width N: the sum or difference.
REQ-014 Port c_out SHALL be an output of width 1: carry-out of the MSB.
REQ-015 Port ovf SHALL be an output of width 1: two's-complement signed overflow.
REQ-016 Port zero SHALL be an output of width 1: asserted when out == 0.

Function
REQ-017 A transfer SHALL occur on any rising edge where in_valid && in_ready; a result SHALL retire on any rising edge where out_valid && out_ready.
REQ-018 The block SHALL compute {c_out,out} = A + (sub ? ~B : B) + c_in, with a full (N+1)-bit sum; for A - B, sub=1 and c_in=1.
REQ-019 ovf SHALL be 1 iff A[N-1] == B'[N-1] and out[N-1] != A[N-1], where B' is the effective operand.
REQ-020 Stage k (0..STAGES-1) SHALL add slice bits [(k+1)W-1:kW], with W = N/STAGES, using the carry registered from stage k-1; stage 0 SHALL use c_in.
REQ-021 Upper operand slices and completed lower result slices SHALL be carried forward in pipeline registers so that each result is time-aligned.
REQ-022 When unstalled, latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1 with the matching result.
REQ-023 Throughput SHALL be one operation per cycle when out_ready=1.
REQ-024 Stall: advance = out_ready || !out_valid, and in_ready SHALL equal advance combinationally.
REQ-025 When advance=0, every stage register and every valid bit SHALL hold, and out, c_out, ovf and zero SHALL remain stable.
REQ-026 Bubbles (in_valid=0 on an advancing cycle) SHALL propagate as valid=0 and SHALL NOT be retired.
REQ-027 Results SHALL emerge in acceptance order with no loss or duplication.
REQ-028 Simultaneous retire and accept in one cycle SHALL both take effect.
REQ-029 In the STAGES=1 case, the output register SHALL be the only stage, with latency 1.

Reset
REQ-030 Asserting rst SHALL asynchronously clear all valid bits, so that out_valid=0 immediately.
REQ-031 On reset, out, c_out, ovf and zero SHALL be 0, and operations in flight SHALL be discarded.
REQ-032 After rst deasserts, in_ready SHALL be 1 on the first cycle.

Structure
REQ-033 Package nbit_pipe_pkg SHALL hold default constants (N_DEF=32, STAGES_DEF=4), the mode encoding (MODE_ADD=0, MODE_SUB=1) and a slice-width helper function.
REQ-034 Sub-module addsub_slice SHALL be a W-bit registered slice adder with carry in and out, and hold enable, instantiated STAGES times via generate.
REQ-035 Flags SHALL be computed in the final stage from registered MSB data.

Verification
REQ-036 N=32, STAGES=4, out_ready=1: A=0xFFFFFFFF, B=0x00000001, c_in=0, sub=0 -> after 4 cycles, out=0x00000000, c_out=1, zero=1, ovf=0.
REQ-037 Subtract: A=0x80000000, B=0x00000001, sub=1, c_in=1 -> out=0x7FFFFFFF, c_out=1, ovf=1.
REQ-038 Streaming with backpressure: 8 back-to-back operations A=i, B=i (i=0..7), with out_ready=0 on cycles 5-7 -> in_ready=0 during the stall, outputs held stable, results 0,2,...,14 in order with no loss.
REQ-039 Carry crossing every slice: A=0x00FFFFFF, B=0x00000001, c_in=1 -> out=0x01000001, c_out=0.
REQ-040 Reset mid-operation: rst pulsed with 3 operations in flight -> out_valid=0 at once, and no stale result appears afterwards.
REQ-041 Parameter sweep: STAGES in {1,2,8,32} with N=32, and N=8, STAGES=2 -> random 1000-operation check against a reference model with latency equal to STAGES.

Source files
------------

// File: rtl/nbit_pipe_pkg.sv
// Shared constants and helpers for the pipelined N-bit adder/subtractor.
// Holds default geometry, the add/subtract mode encoding and the slice-width helper.
package nbit_pipe_pkg;

  localparam int N_DEF      = 32;
  localparam int STAGES_DEF = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Each pipeline stage resolves an equal-width slice of the operands.
  function automatic int slice_width(input int n, input int stages);
    return n / stages;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One W-bit registered slice adder: sums a, b and the incoming carry,
// then captures the sum and carry-out when enabled.
module addsub_slice
  import nbit_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  logic [W:0] total;

  // NOTE: always_comb assigns total on every path, so no latch can be inferred.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else if (en) begin
      sum   <= total[W-1:0];
      c_out <= total[W];
    end
  end

endmodule

// File: rtl/nbit_pipe_addsub.sv
// Pipelined N-bit adder/subtractor with valid/ready handshakes on both sides.
// Stage k resolves operand slice k; the carry ripples through one register per stage.
module nbit_pipe_addsub
  import nbit_pipe_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] reg_in0,
  input  logic [N-1:0] reg_in1,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int W = slice_width(N, STAGES);
  localparam logic [N-1:0] SLICE_ONES = {N{1'b1}} >> (N - W);

  logic              advance;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] slice_c;
  logic [N-1:0]      src_a    [STAGES];
  logic [N-1:0]      src_b    [STAGES];
  logic [N-1:0]      pass_q   [STAGES];
  logic [N-1:0]      b_pass_q [STAGES];
  logic [N-1:0]      view     [STAGES];
  logic [W-1:0]      slice_sum[STAGES];
  logic              a_msb_q;

  // The whole pipe moves as one: it freezes only when a held result is not taken.
  assign advance   = out_ready || !out_valid;
  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_a[k] = reg_in0;
      assign src_b[k] = (sub == MODE_SUB) ? ~reg_in1 : reg_in1;
      assign src_c[k] = c_in;
      assign src_v[k] = in_valid;
    end else begin : g_next
      assign src_a[k] = view[k-1];
      assign src_b[k] = b_pass_q[k-1];
      assign src_c[k] = slice_c[k-1];
      assign src_v[k] = valid_q[k-1];
    end

    addsub_slice #(.W(W)) u_slice (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .a     (src_a[k][k*W +: W]),
      .b     (src_b[k][k*W +: W]),
      .c_in  (src_c[k]),
      .sum   (slice_sum[k]),
      .c_out (slice_c[k])
    );

    // Lower slices hold finished result bits, upper slices still hold operand A.
    assign view[k] = pass_q[k] | (N'(slice_sum[k]) << (k*W));
  end

  // NOTE: the data path is reset, not just the valid bits, so out reads 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      a_msb_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        pass_q[k]   <= '0;
        b_pass_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= src_v;
      a_msb_q <= src_a[STAGES-1][N-1];
      for (int k = 0; k < STAGES; k++) begin
        pass_q[k]   <= src_a[k] & ~(SLICE_ONES << (k*W));
        b_pass_q[k] <= src_b[k];
      end
    end
  end

  assign out   = view[STAGES-1];
  assign c_out = slice_c[STAGES-1];

  // Flags come from registered MSBs and are masked while no result is presented.
  assign ovf  = out_valid && (a_msb_q == b_pass_q[STAGES-1][N-1]) && (out[N-1] != a_msb_q);
  assign zero = out_valid && (out == '0);

endmodule

// File: tb/tb_nbit_pipe_addsub.sv
// Self-checking bench for nbit_pipe_addsub: directed vectors on a 32x4 instance
// plus a randomized scoreboard sweep over several N/STAGES configurations.
module tb_nbit_pipe_addsub;
  import nbit_pipe_pkg::*;

  typedef struct {
    logic [31:0] out;
    logic        co;
    logic        ovf;
    logic        z;
    int          t;
    logic        stalled;
  } exp_t;

  function automatic int sw_n(input int g);
    return (g == 4) ? 8 : 32;
  endfunction

  function automatic int sw_s(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 8;
      3:       return 32;
      default: return 2;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Main 32x4 instance
  logic        m_iv, m_ir, m_cin, m_sub, m_ov, m_ordy, m_co, m_ovf, m_z;
  logic [31:0] m_a, m_b, m_out;
  exp_t        m_q[$];
  logic        m_took;
  int          m_last_t;
  int          m_retired;

  nbit_pipe_addsub #(.N(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_iv),
    .in_ready  (m_ir),
    .reg_in0   (m_a),
    .reg_in1   (m_b),
    .c_in      (m_cin),
    .sub       (m_sub),
    .out_valid (m_ov),
    .out_ready (m_ordy),
    .out       (m_out),
    .c_out     (m_co),
    .ovf       (m_ovf),
    .zero      (m_z)
  );

  // Sweep instances share stimulus and out_ready
  logic        sw_iv, sw_cin, sw_sub, sw_ordy;
  logic [31:0] sw_a, sw_b;
  logic [4:0]  sw_ir, sw_ov, sw_co, sw_ovf, sw_z;
  logic [31:0] sw_out [5];
  exp_t        sw_q [5][$];
  int          sw_acc [5];

  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int GN = sw_n(g);
    localparam int GS = sw_s(g);
    logic [GN-1:0] o;
    nbit_pipe_addsub #(.N(GN), .STAGES(GS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_iv),
      .in_ready  (sw_ir[g]),
      .reg_in0   (sw_a[GN-1:0]),
      .reg_in1   (sw_b[GN-1:0]),
      .c_in      (sw_cin),
      .sub       (sw_sub),
      .out_valid (sw_ov[g]),
      .out_ready (sw_ordy),
      .out       (o),
      .c_out     (sw_co[g]),
      .ovf       (sw_ovf[g]),
      .zero      (sw_z[g])
    );
    assign sw_out[g] = 32'(o);
  end

  // Reference: plain (n+1)-bit arithmetic, independent of the slicing.
  function automatic exp_t ref_calc(input int n, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sb);
    exp_t        r;
    logic [31:0] m, bb, o;
    logic [63:0] s;
    m  = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    bb = (sb ? ~b : b) & m;
    s  = {32'd0, a & m} + {32'd0, bb} + {63'd0, cin};
    o  = s[31:0] & m;
    r.out     = o;
    r.co      = s[n];
    r.ovf     = (a[n-1] == bb[n-1]) && (o[n-1] != a[n-1]);
    r.z       = (o == 32'd0);
    r.t       = 0;
    r.stalled = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // One clock: observe handshakes at the falling edge, run the scoreboards,
  // then return just after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    m_took = 1'b0;
    if (m_ov && !m_ordy)
      for (int i = 0; i < m_q.size(); i++) m_q[i].stalled = 1'b1;
    if (m_ov && m_ordy) begin
      checks++;
      m_retired++;
      if (m_q.size() == 0) begin
        errors++;
        $display("FAIL main_spurious: out_valid with out=%h, expected no result", m_out);
      end else begin
        e = m_q.pop_front();
        if ({m_out, m_co, m_ovf, m_z} !== {e.out, e.co, e.ovf, e.z}) begin
          errors++;
          $display("FAIL main_result: got out=%h c=%b v=%b z=%b, expected out=%h c=%b v=%b z=%b",
                   m_out, m_co, m_ovf, m_z, e.out, e.co, e.ovf, e.z);
        end
        if (!e.stalled) begin
          checks++;
          if (cyc - e.t != 4) begin
            errors++;
            $display("FAIL main_latency: got %0d, expected 4", cyc - e.t);
          end
        end
      end
    end
    if (m_iv && m_ir) begin
      e = ref_calc(32, m_a, m_b, m_cin, m_sub);
      e.t = cyc;
      m_q.push_back(e);
      m_took   = 1'b1;
      m_last_t = cyc;
    end
    for (int g = 0; g < 5; g++) begin
      if (sw_ov[g] && !sw_ordy)
        for (int i = 0; i < sw_q[g].size(); i++) sw_q[g][i].stalled = 1'b1;
      if (sw_ov[g] && sw_ordy) begin
        checks++;
        if (sw_q[g].size() == 0) begin
          errors++;
          $display("FAIL sweep%0d_spurious: out_valid with out=%h, expected no result", g, sw_out[g]);
        end else begin
          e = sw_q[g].pop_front();
          if ({sw_out[g], sw_co[g], sw_ovf[g], sw_z[g]} !== {e.out, e.co, e.ovf, e.z}) begin
            errors++;
            $display("FAIL sweep%0d_result: got out=%h c=%b v=%b z=%b, expected out=%h c=%b v=%b z=%b",
                     g, sw_out[g], sw_co[g], sw_ovf[g], sw_z[g], e.out, e.co, e.ovf, e.z);
          end
          if (!e.stalled) begin
            checks++;
            if (cyc - e.t != sw_s(g)) begin
              errors++;
              $display("FAIL sweep%0d_latency: got %0d, expected %0d", g, cyc - e.t, sw_s(g));
            end
          end
        end
      end
      if (sw_iv && sw_ir[g]) begin
        e = ref_calc(sw_n(g), sw_a, sw_b, sw_cin, sw_sub);
        e.t = cyc;
        sw_q[g].push_back(e);
        sw_acc[g]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sb, output int t_acc);
    m_a = a; m_b = b; m_cin = cin; m_sub = sb; m_iv = 1'b1;
    t_acc = -1;
    for (int k = 0; k < 20 && t_acc < 0; k++) begin
      step();
      if (m_took) t_acc = m_last_t;
    end
    m_iv = 1'b0;
    checks++;
    if (t_acc < 0) begin
      errors++;
      $display("FAIL issue_timeout: in_ready never seen, expected acceptance");
    end
  endtask

  task automatic wait_out();
    for (int k = 0; k < 12 && !m_ov; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({m_ov, m_out, m_co, m_ovf, m_z} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b out=%h c=%b o=%b z=%b, expected all 0",
               m_ov, m_out, m_co, m_ovf, m_z);
    end
    checks++;
    if (sw_ov !== 5'd0) begin
      errors++;
      $display("FAIL reset_sweep_valid: got %b, expected 00000", sw_ov);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_ir !== 1'b1 || sw_ir !== 5'b11111) begin
      errors++;
      $display("FAIL reset_in_ready: got main=%b sweep=%b, expected 1/11111", m_ir, sw_ir);
    end
  endtask

  task automatic test_add_wrap();
    int t;
    m_ordy = 1'b0;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, t);
    wait_out();
    checks++;
    if (!m_ov || cyc - t != 4) begin
      errors++;
      $display("FAIL add_wrap_latency: got valid=%b after %0d, expected valid after 4", m_ov, cyc - t);
    end
    checks++;
    if ({m_out, m_co, m_z, m_ovf} !== {32'h0000_0000, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_wrap_value: got out=%h c=%b z=%b v=%b, expected 00000000 1 1 0",
               m_out, m_co, m_z, m_ovf);
    end
    m_ordy = 1'b1;
    step();
  endtask

  task automatic test_sub_ovf();
    int t;
    m_ordy = 1'b0;
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, MODE_SUB, t);
    wait_out();
    checks++;
    if (!m_ov || {m_out, m_co, m_ovf, m_z} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_ovf_value: got valid=%b out=%h c=%b v=%b z=%b, expected 7fffffff 1 1 0",
               m_ov, m_out, m_co, m_ovf, m_z);
    end
    m_ordy = 1'b1;
    step();
  endtask

  task automatic test_carry_chain();
    int t;
    m_ordy = 1'b0;
    issue(32'h00FF_FFFF, 32'h0000_0001, 1'b1, MODE_ADD, t);
    wait_out();
    checks++;
    if (!m_ov || {m_out, m_co, m_ovf, m_z} !== {32'h0100_0001, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL carry_chain_value: got valid=%b out=%h c=%b v=%b z=%b, expected 01000001 0 0 0",
               m_ov, m_out, m_co, m_ovf, m_z);
    end
    m_ordy = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int          next = 0;
    int          base;
    logic [34:0] snap;
    base = m_retired;
    m_cin = 1'b0; m_sub = MODE_ADD;
    for (int j = 0; j < 40 && (next < 8 || m_q.size() != 0); j++) begin
      m_ordy = !(j >= 5 && j <= 7);
      m_iv   = (next < 8);
      m_a    = 32'(next);
      m_b    = 32'(next);
      #1;
      if (j >= 5 && j <= 7) begin
        checks++;
        if (m_ir !== 1'b0 || m_ov !== 1'b1) begin
          errors++;
          $display("FAIL stall_ready: cycle %0d got in_ready=%b out_valid=%b, expected 0/1", j, m_ir, m_ov);
        end
        if (j == 5) snap = {m_out, m_co, m_ovf, m_z};
        else begin
          checks++;
          if ({m_out, m_co, m_ovf, m_z} !== snap) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got %h, expected %h", j, {m_out, m_co, m_ovf, m_z}, snap);
          end
        end
      end
      step();
      if (m_took) next++;
    end
    m_iv = 1'b0;
    m_ordy = 1'b1;
    checks++;
    if (m_retired - base != 8 || m_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d retired, %0d pending, expected 8 and 0",
               m_retired - base, m_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    m_ordy = 1'b0;
    m_iv   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_a = 32'h1000 + 32'(i); m_b = 32'h0000_0100; m_cin = 1'b0; m_sub = MODE_ADD;
      step();
    end
    m_iv = 1'b0;
    wait_out();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_ov, m_out, m_co, m_ovf, m_z} !== 36'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got v=%b out=%h c=%b o=%b z=%b, expected all 0",
               m_ov, m_out, m_co, m_ovf, m_z);
    end
    m_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_ir !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b, expected 1", m_ir);
    end
    m_ordy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (m_ov) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_stale: got %0d stale results, expected 0", seen);
    end
  endtask

  task automatic test_param_sweep();
    int min_acc = 0;
    for (int k = 0; k < 6000 && min_acc < 1000; k++) begin
      sw_ordy = (k < 600) ? 1'b1 : ($urandom_range(0, 9) < 7);
      sw_iv   = ($urandom_range(0, 9) < 8);
      sw_a    = pick();
      sw_b    = ($urandom_range(0, 7) == 0) ? sw_a : pick();
      sw_cin  = $urandom_range(0, 1);
      sw_sub  = $urandom_range(0, 1);
      step();
      min_acc = sw_acc[0];
      for (int g = 1; g < 5; g++) if (sw_acc[g] < min_acc) min_acc = sw_acc[g];
    end
    sw_iv = 1'b0;
    sw_ordy = 1'b1;
    for (int k = 0; k < 40; k++) step();
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (sw_q[g].size() != 0 || sw_acc[g] < 1000) begin
        errors++;
        $display("FAIL sweep%0d_drain: got %0d accepted, %0d pending, expected >=1000 and 0",
                 g, sw_acc[g], sw_q[g].size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m_iv = 1'b0; m_ordy = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
    sw_iv = 1'b0; sw_ordy = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    m_took = 1'b0; m_last_t = 0; m_retired = 0;
    for (int g = 0; g < 5; g++) sw_acc[g] = 0;
    test_reset();
    test_add_wrap();
    test_sub_ovf();
    test_carry_chain();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
